ifft_twiddle_fetch: RTL and testbench

Sequencer on the read side of the IFFT twiddle ROMs. After a start pulse, it walks the ROM address space once and drives the shared 5-bit address to the real and imaginary twiddle ROMs. It absorbs their one-cycle read latency and presents each twiddle pair to the butterfly datapath on a valid/ready stream. It sits between the stage controller, which issues `start` and observes `done`, and the butterfly, which consumes the stream.

---
 rtl/ifft_pkg.sv | 30 +++
 rtl/ifft_tw_skid_fifo.sv | 49 ++++
 rtl/ifft_twiddle_fetch.sv | 97 +++++++++
 tb/tb_ifft_twiddle_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_pkg.sv
// Shared definitions for the IFFT twiddle read path: ROM geometry, Q8 constants,
// sequencer state encoding and the twiddle entry carried through the skid FIFO.
package ifft_pkg;

  localparam int unsigned DEPTH  = 28;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] Q8_ONE = 16'h0100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } tw_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [ADDR_W-1:0] idx;
  } tw_entry_t;

  // Two's-complement negate that maps the most negative code to the most positive one.
  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      return {1'b0, {(DATA_W-1){1'b1}}};
    return (~x) + 1'b1;
  endfunction

endpackage

// File: rtl/ifft_tw_skid_fifo.sv
// Two-entry first-word-fall-through FIFO of twiddle entries with occupancy count.
// When empty, an incoming write is visible at the head in the same cycle.
module ifft_tw_skid_fifo
  import ifft_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  tw_entry_t wr_data,
  input  logic      rd_en,
  output logic      valid,
  output tw_entry_t head,
  output logic [1:0] count
);

  tw_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      pop;
  logic      store;
  logic      take;

  assign valid = (count != 2'd0) | wr_en;
  assign head  = (count != 2'd0) ? mem[rd_ptr] : (wr_en ? wr_data : '0);
  assign pop   = rd_en & valid;
  // A write consumed in the same cycle by an empty FIFO bypasses storage entirely.
  assign store = wr_en & ~((count == 2'd0) & pop);
  assign take  = pop & (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count + {1'b0, wr_en} - {1'b0, pop};
      if (store)
        wr_ptr <= ~wr_ptr;
      if (take)
        rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (store)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ifft_twiddle_fetch.sv
// Twiddle ROM read sequencer: walks addresses 0..DEPTH-1 once per start and streams
// {re, im, idx} over valid/ready. Define IFFT_TW_CONJ_EN to emit the conjugate twiddle.
module ifft_twiddle_fetch
  import ifft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re_data,
  input  logic [DATA_W-1:0] rom_im_data,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic [ADDR_W-1:0] tw_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  tw_state_e         state;
  tw_state_e         state_nxt;
  logic              issue;
  logic              rd_pending;
  logic [ADDR_W-1:0] rd_idx;
  logic              hs;
  logic              last_addr;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] im_in;
  tw_entry_t         wr_entry;
  tw_entry_t         head;

`ifdef IFFT_TW_CONJ_EN
  assign im_in = sat_neg(rom_im_data);
`else
  assign im_in = rom_im_data;
`endif

  assign wr_entry  = '{re: rom_re_data, im: im_in, idx: rd_idx};
  assign hs        = tw_valid & tw_ready;
  assign last_addr = (rom_addr == LAST);

  // Credit check: stored + in-flight entries, less the one leaving this cycle, stays below 2.
  assign issue = (state == RUN) &&
                 (({1'b0, fifo_count} + {2'b0, rd_pending}) < (3'd2 + {2'b0, hs}));

  ifft_tw_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rd_pending),
    .wr_data (wr_entry),
    .rd_en   (tw_ready),
    .valid   (tw_valid),
    .head    (head),
    .count   (fifo_count)
  );

  assign tw_re  = head.re;
  assign tw_im  = head.im;
  assign tw_idx = head.idx;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (issue && last_addr) state_nxt = DRAIN;
      DRAIN: begin
        if (hs && (head.idx == LAST)) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      rd_pending <= 1'b0;
      rd_idx     <= '0;
    end else begin
      state      <= state_nxt;
      rd_pending <= issue;
      if (issue) begin
        rd_idx   <= rom_addr;
        rom_addr <= last_addr ? '0 : rom_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifft_twiddle_fetch.sv
// Directed self-checking bench for ifft_twiddle_fetch with a behavioural ROM and stream model.
module tb_ifft_twiddle_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rom_addr;
  logic [15:0] rom_re_data = '0;
  logic [15:0] rom_im_data = '0;
  logic        tw_valid;
  logic        tw_ready = 1'b0;
  logic [15:0] tw_re;
  logic [15:0] tw_im;
  logic [4:0]  tw_idx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int ndone  = 0;
  int npass  = 0;
  int nexp   = 0;

  always #5 clk = ~clk;

  ifft_twiddle_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_re_data (rom_re_data),
    .rom_im_data (rom_im_data),
    .tw_valid    (tw_valid),
    .tw_ready    (tw_ready),
    .tw_re       (tw_re),
    .tw_im       (tw_im),
    .tw_idx      (tw_idx),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [15:0] rom_re_val(input int k);
    return 16'(k);
  endfunction

  function automatic logic [15:0] rom_im_val(input int k);
`ifdef IFFT_TW_CONJ_EN
    if (k == 3) return 16'h00B5;
    if (k == 4) return 16'h8000;
`endif
    return 16'(27 - k);
  endfunction

  function automatic logic [15:0] exp_im(input int k);
    logic signed [15:0] s;
    int v;
    s = rom_im_val(k);
    v = s;
`ifdef IFFT_TW_CONJ_EN
    v = -v;
    if (v > 32767) v = 32767;
`endif
    return 16'(v);
  endfunction

  // Twiddle ROM pair: one-cycle registered read.
  always @(posedge clk) begin
    rom_re_data <= rom_re_val(int'(rom_addr));
    rom_im_data <= rom_im_val(int'(rom_addr));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: indices 0..27 in order, ROM-derived values, hold while stalled.
  logic        prev_stall = 1'b0;
  logic [15:0] h_re, h_im;
  logic [4:0]  h_idx;

  always @(negedge clk) begin
    if (rst) begin
      nexp       = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(tw_valid), 32'd1);
        chk("hold_re", 32'(tw_re), 32'(h_re));
        chk("hold_im", 32'(tw_im), 32'(h_im));
        chk("hold_idx", 32'(tw_idx), 32'(h_idx));
      end
      if (tw_valid) begin
        chk("stream_idx", 32'(tw_idx), 32'(nexp));
        chk("stream_re", 32'(tw_re), 32'(rom_re_val(nexp)));
        chk("stream_im", 32'(tw_im), 32'(exp_im(nexp)));
      end
      chk("done_pulse", 32'(done), 32'(tw_valid & tw_ready & (nexp == 27)));
      if (done) ndone++;
      if (tw_valid && tw_ready) begin
        if (nexp == 27) begin
          nexp = 0;
          npass++;
        end else begin
          nexp++;
        end
      end
      prev_stall = tw_valid & ~tw_ready;
      h_re  = tw_re;
      h_im  = tw_im;
      h_idx = tw_idx;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int mode, input int budget);
    int c;
    int d0;
    c  = 0;
    d0 = ndone;
    while (ndone == d0 && c < budget) begin
      if (mode == 1) tw_ready = (c % 2 == 0);
      else           tw_ready = 1'b1;
      step();
      c++;
    end
    chk("pass_done_in_budget", 32'(ndone - d0), 32'd1);
    tw_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int p0;
    int c;
    logic fired10;
    logic seen;

    // Reset values
    repeat (3) step();
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_tw_valid", 32'(tw_valid), 32'd0);
    chk("rst_tw_re", 32'(tw_re), 32'd0);
    chk("rst_tw_im", 32'(tw_im), 32'd0);
    chk("rst_tw_idx", 32'(tw_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    // Pass 1: ready held high, literal timing
    tw_ready = 1'b1;
    d0 = ndone;
    p0 = npass;
    do_start();
    chk("t1_busy_e1", 32'(busy), 32'd1);
    chk("t1_addr_e1", 32'(rom_addr), 32'd0);
    chk("t1_valid_e1", 32'(tw_valid), 32'd0);
    step();
    chk("t1_valid_e2", 32'(tw_valid), 32'd1);
    chk("t1_idx_e2", 32'(tw_idx), 32'd0);
    chk("t1_re_e2", 32'(tw_re), 32'h0000);
`ifdef IFFT_TW_CONJ_EN
    chk("t1_im_e2", 32'(tw_im), 32'h0000FFE5);
`else
    chk("t1_im_e2", 32'(tw_im), 32'h001B);
`endif
    chk("t1_addr_e2", 32'(rom_addr), 32'd1);
    for (int e = 3; e <= 29; e++) begin
      step();
`ifdef IFFT_TW_CONJ_EN
      if (e == 5) chk("conj_im_00B5", 32'(tw_im), 32'h0000FF4B);
      if (e == 6) chk("conj_im_8000", 32'(tw_im), 32'h00007FFF);
`endif
      if (e == 28) chk("t1_done_e28", 32'(done), 32'd0);
    end
    chk("t1_idx_e29", 32'(tw_idx), 32'd27);
    chk("t1_done_e29", 32'(done), 32'd1);
    chk("t1_busy_e29", 32'(busy), 32'd1);
    step();
    chk("t1_busy_e30", 32'(busy), 32'd0);
    chk("t1_done_e30", 32'(done), 32'd0);
    chk("t1_valid_e30", 32'(tw_valid), 32'd0);
    chk("t1_ndone", 32'(ndone - d0), 32'd1);
    chk("t1_npass", 32'(npass - p0), 32'd1);
    step();

    // Pass 2: ready toggling 1010...
    p0 = npass;
    do_start();
    run_to_done(1, 200);
    chk("t2_npass", 32'(npass - p0), 32'd1);
    repeat (2) step();

    // Pass 3: ready low for 10 cycles after the first valid
    p0 = npass;
    tw_ready = 1'b0;
    do_start();
    step();
    chk("t3_valid_e2", 32'(tw_valid), 32'd1);
    for (int e = 3; e <= 12; e++) begin
      step();
      if (e == 5 || e == 12) begin
        chk("t3_addr_stalled", 32'(rom_addr), 32'd2);
        chk("t3_idx_held", 32'(tw_idx), 32'd0);
      end
    end
    run_to_done(0, 200);
    chk("t3_npass", 32'(npass - p0), 32'd1);
    repeat (2) step();

    // Pass 4: start re-pulsed at idx 10 and in the done cycle
    tw_ready = 1'b1;
    d0 = ndone;
    fired10 = 1'b0;
    seen = 1'b0;
    c = 0;
    do_start();
    while (!seen && c < 200) begin
      if (tw_valid && tw_idx == 5'd10 && !fired10) begin
        start = 1'b1;
        fired10 = 1'b1;
      end
      if (done) begin
        start = 1'b1;
        seen = 1'b1;
      end
      step();
      start = 1'b0;
      c++;
    end
    chk("t4_done_seen", 32'(seen), 32'd1);
    chk("t4_busy_after_done", 32'(busy), 32'd0);
    repeat (4) step();
    chk("t4_busy_idle", 32'(busy), 32'd0);
    chk("t4_valid_idle", 32'(tw_valid), 32'd0);
    chk("t4_ndone", 32'(ndone - d0), 32'd1);

    // Pass 5: reset at idx 15, then a clean pass
    d0 = ndone;
    c = 0;
    do_start();
    while (!(tw_valid && tw_idx == 5'd15) && c < 100) begin
      step();
      c++;
    end
    chk("t5_reached_idx15", 32'(tw_valid && tw_idx == 5'd15), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid_after_rst", 32'(tw_valid), 32'd0);
    chk("t5_addr_after_rst", 32'(rom_addr), 32'd0);
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    chk("t5_done_after_rst", 32'(done), 32'd0);
    repeat (3) step();
    chk("t5_valid_quiet", 32'(tw_valid), 32'd0);
    chk("t5_no_done", 32'(ndone - d0), 32'd0);
    p0 = npass;
    do_start();
    run_to_done(0, 200);
    chk("t5_npass", 32'(npass - p0), 32'd1);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
